// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package fetch_pkg;
    localparam int PC_W        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/pc_target_calc.sv
// Redirect target arithmetic: branch/JAL (PCE + imm*2) or JALR (ALU result, bit 0 cleared).
module pc_target_calc
    import fetch_pkg::*;
(
    input  logic [PC_W-1:0] PCE,
    input  logic [PC_W-1:0] ImmExtE,
    input  logic [PC_W-1:0] ALUResultE,
    input  logic            JalrE,
    output logic [PC_W-1:0] target_o,
    output logic            raw_bit1_o
);
    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] jalr_target;
    logic [PC_W-1:0] raw_target;

    always_comb begin
        branch_target = PCE + (ImmExtE << 1);
        jalr_target   = ALUResultE & ~32'h1;
        raw_target    = JalrE ? jalr_target : branch_target;
        raw_bit1_o    = raw_target[1];
        // Fetch only supports word-aligned PCs, so bit 1 is dropped after flagging it.
        target_o      = raw_target & ~32'h2;
    end
endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC register with boot hold, stall/redirect arbitration, pending-redirect buffer
// and a saturating redirect counter.
module fetch_pc_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          BOOT_CYCLES = 1,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             PCSrcE,
    input  logic             JalrE,
    input  logic [31:0]      PCE,
    input  logic [31:0]      ImmExtE,
    input  logic [31:0]      ALUResultE,
    output logic [31:0]      PCF,
    output logic [31:0]      PCPlus4F,
    output logic             FlushD,
    output logic             FlushE,
    output logic             MisalignE,
    output logic [CNT_W-1:0] RedirectCount
);
    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pend_q, pend_d;
    logic [3:0]        boot_cnt_q, boot_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [PC_W-1:0]   target;
    logic              raw_bit1;
    logic              redirect;
    logic              count_en;

    pc_target_calc u_target (
        .PCE        (PCE),
        .ImmExtE    (ImmExtE),
        .ALUResultE (ALUResultE),
        .JalrE      (JalrE),
        .target_o   (target),
        .raw_bit1_o (raw_bit1)
    );

    assign redirect      = PCSrcE | JalrE;
    assign MisalignE     = redirect & raw_bit1;
    assign PCF           = pc_q;
    assign PCPlus4F      = pc_q + 32'(INSTR_BYTES);
    assign RedirectCount = cnt_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        boot_cnt_d = boot_cnt_q;
        count_en   = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;

        case (state_q)
            BOOT: begin
                // Instruction memory is still warming up: keep IF/ID squashed.
                FlushD     = 1'b1;
                boot_cnt_d = boot_cnt_q + 4'd1;
                if (boot_cnt_q == 4'(BOOT_CYCLES - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (redirect) begin
                    FlushD   = 1'b1;
                    FlushE   = 1'b1;
                    count_en = 1'b1;
                    if (StallF) begin
                        pend_d  = target;
                        state_d = HOLD;
                    end else begin
                        pc_d = target;
                    end
                end else if (!StallF) begin
                    pc_d = PCPlus4F;
                end
            end
            HOLD: begin
                if (redirect) begin
                    FlushD   = 1'b1;
                    FlushE   = 1'b1;
                    count_en = 1'b1;
                    pend_d   = target;
                end
                if (!StallF) begin
                    pc_d    = redirect ? target : pend_q;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        cnt_d = cnt_q;
        if (count_en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            boot_cnt_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            boot_cnt_q <= boot_cnt_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed-vector bench for fetch_pc_sequencer (small counter width to reach saturation).
module tb_fetch_pc_sequencer;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             StallF;
    logic             PCSrcE;
    logic             JalrE;
    logic [31:0]      PCE;
    logic [31:0]      ImmExtE;
    logic [31:0]      ALUResultE;
    logic [31:0]      PCF;
    logic [31:0]      PCPlus4F;
    logic             FlushD;
    logic             FlushE;
    logic             MisalignE;
    logic [CNT_W-1:0] RedirectCount;

    int n_vec = 0;
    int n_bad = 0;

    fetch_pc_sequencer #(
        .RESET_PC    (32'h0000_0000),
        .BOOT_CYCLES (1),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .StallF        (StallF),
        .PCSrcE        (PCSrcE),
        .JalrE         (JalrE),
        .PCE           (PCE),
        .ImmExtE       (ImmExtE),
        .ALUResultE    (ALUResultE),
        .PCF           (PCF),
        .PCPlus4F      (PCPlus4F),
        .FlushD        (FlushD),
        .FlushE        (FlushE),
        .MisalignE     (MisalignE),
        .RedirectCount (RedirectCount)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        PCSrcE = 1'b0; JalrE = 1'b0;
        PCE = 32'h0; ImmExtE = 32'h0; ALUResultE = 32'h0;
    endtask

    task automatic branch(input logic [31:0] pc, input logic [31:0] imm);
        PCSrcE = 1'b1; JalrE = 1'b0; PCE = pc; ImmExtE = imm; ALUResultE = 32'h0;
    endtask

    initial begin
        reset = 1'b1; StallF = 1'b0; idle();
        tick(); tick();
        reset = 1'b0;

        // BOOT cycle, then one RUN cycle at reset PC, then sequential.
        settle();
        check_vec("boot_pcf",    PCF, 32'h0);
        check_vec("boot_flushd", 32'(FlushD), 32'h1);
        check_vec("boot_flushe", 32'(FlushE), 32'h0);
        check_vec("boot_cnt",    32'(RedirectCount), 32'h0);
        tick(); settle();
        check_vec("run0_pcf",    PCF, 32'h0);
        check_vec("run0_flushd", 32'(FlushD), 32'h0);
        tick(); settle();
        check_vec("seq_pcf_4",   PCF, 32'h4);
        check_vec("seq_plus4",   PCPlus4F, 32'h8);
        tick(); settle();
        check_vec("seq_pcf_8",   PCF, 32'h8);
        tick(); tick(); settle();
        check_vec("seq_pcf_10",  PCF, 32'h10);

        // Branch 0x8 + (0x8<<1) = 0x18.
        branch(32'h8, 32'h8); settle();
        check_vec("br_flushd",   32'(FlushD), 32'h1);
        check_vec("br_flushe",   32'(FlushE), 32'h1);
        check_vec("br_misalign", 32'(MisalignE), 32'h0);
        tick(); idle(); settle();
        check_vec("br_pcf",      PCF, 32'h18);
        check_vec("br_cnt",      32'(RedirectCount), 32'h1);
        check_vec("br_noflush",  32'(FlushE), 32'h0);

        // JALR wins over branch; bit 0 cleared.
        branch(32'h8, 32'h8); JalrE = 1'b1; ALUResultE = 32'h101; settle();
        check_vec("jalr_misalign", 32'(MisalignE), 32'h0);
        tick(); idle(); settle();
        check_vec("jalr_pcf",    PCF, 32'h100);
        check_vec("jalr_cnt",    32'(RedirectCount), 32'h2);

        // Redirect to 0x40 while stalled for 3 cycles.
        StallF = 1'b1; branch(32'h30, 32'h8); settle();
        check_vec("stl_flushd",  32'(FlushD), 32'h1);
        tick(); idle(); settle();
        check_vec("stl_pcf1",    PCF, 32'h100);
        check_vec("stl_flush1",  32'(FlushD), 32'h0);
        tick(); settle();
        check_vec("stl_pcf2",    PCF, 32'h100);
        StallF = 1'b0; settle();
        check_vec("rel_flushe",  32'(FlushE), 32'h0);
        tick(); settle();
        check_vec("rel_pcf",     PCF, 32'h40);
        check_vec("rel_cnt",     32'(RedirectCount), 32'h3);

        // Pending 0x40 overwritten by 0x80 while still stalled.
        StallF = 1'b1; branch(32'h30, 32'h8);
        tick(); branch(32'h70, 32'h8); settle();
        check_vec("ovw_flushe",  32'(FlushE), 32'h1);
        tick(); idle(); settle();
        check_vec("ovw_hold",    PCF, 32'h40);
        StallF = 1'b0;
        tick(); settle();
        check_vec("ovw_pcf",     PCF, 32'h80);
        check_vec("ovw_cnt",     32'(RedirectCount), 32'h5);

        // Raw target 0x22 flags misalignment and fetches 0x20.
        branch(32'h20, 32'h1); settle();
        check_vec("mis_flag",    32'(MisalignE), 32'h1);
        tick(); idle(); settle();
        check_vec("mis_pcf",     PCF, 32'h20);
        check_vec("mis_clear",   32'(MisalignE), 32'h0);
        check_vec("mis_cnt",     32'(RedirectCount), 32'h6);

        // Reset while in HOLD.
        StallF = 1'b1; branch(32'h30, 32'h8);
        tick(); idle(); reset = 1'b1;
        tick(); reset = 1'b0; StallF = 1'b0; settle();
        check_vec("rst_hold_pcf",    PCF, 32'h0);
        check_vec("rst_hold_cnt",    32'(RedirectCount), 32'h0);
        check_vec("rst_hold_flushd", 32'(FlushD), 32'h1);

        // Redirect during BOOT is ignored.
        branch(32'h30, 32'h8); settle();
        check_vec("boot_ign_flushe", 32'(FlushE), 32'h0);
        tick(); idle(); settle();
        check_vec("boot_ign_pcf",    PCF, 32'h0);
        check_vec("boot_ign_cnt",    32'(RedirectCount), 32'h0);

        // Wrap: redirect to 0xFFFFFFFC, then sequential wraps to 0.
        branch(32'hFFFF_FFF0, 32'h6);
        tick(); idle(); settle();
        check_vec("wrap_pcf",    PCF, 32'hFFFF_FFFC);
        check_vec("wrap_plus4",  PCPlus4F, 32'h0);
        tick(); settle();
        check_vec("wrap_pcf0",   PCF, 32'h0);

        // Counter saturates at 7 (CNT_W=3).
        for (int i = 0; i < 8; i++) begin
            branch(32'h0, 32'h10);
            tick(); idle(); settle();
            check_vec($sformatf("sat_cnt_%0d", i), 32'(RedirectCount),
                      (i + 2 > 7) ? 32'd7 : 32'(i + 2));
        end
        check_vec("sat_pcf", PCF, 32'h20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
- Owns the fetch-stage PC register and sequences next-PC selection for the 5-stage pipeline: sequential (PCPlus4F), branch/JAL redirect (PCE + (ImmExtE << 1)), or JALR redirect (ALUResultE with bit 0 cleared).
- Arbitrates between hazard-unit stalls and execute-stage redirects, and buffers a redirect that arrives while fetch is stalled.
- Generates the decode/execute flushes and a saturating redirect counter.
- Sits between the hazard unit, the execute stage and instruction memory; replaces the bare next-PC mux.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BOOT_CYCLES, 1, cycles the PC is held at RESET_PC after reset release (instruction memory warm-up); legal range 1..15.
- CNT_W, 16, width of the redirect performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- StallF  in  1  hazard-unit fetch stall; holds PCF.
- PCSrcE  in  1  branch taken or JAL in execute.
- JalrE  in  1  JALR in execute; has priority over PCSrcE.
- PCE  in  32  PC of the execute-stage instruction.
- ImmExtE  in  32  sign-extended immediate of the execute-stage instruction.
- ALUResultE  in  32  JALR target from the ALU.
- PCF  out  32  current fetch PC (registered).
- PCPlus4F  out  32  PCF + 4, combinational.
- FlushD  out  1  squash the IF/ID register.
- FlushE  out  1  squash the ID/EX register.
- MisalignE  out  1  redirect target had bit 1 set.
- RedirectCount  out  CNT_W  number of redirects taken, saturating.

Behaviour:
- Reset (clk edge with reset=1): PCF=RESET_PC, state=BOOT, boot counter=0, pending register cleared, RedirectCount=0. Reset overrides every other input, including reset asserted mid-redirect or mid-HOLD.
- Target arithmetic, 32-bit with wrap-around and carries discarded:
  - Branch target = PCE + (ImmExtE << 1).
  - JALR target = ALUResultE & ~32'h1.
  - The final target has bit 1 forced to 0.
  - MisalignE = redirect & (raw target bit 1 before forcing). It is combinational and affects only that cycle.
- redirect = PCSrcE | JalrE.
- States:
  - BOOT:
    - PCF is held. FlushD=1, FlushE=0.
    - Redirect inputs are ignored and not counted.
    - Counter increments each cycle. After BOOT_CYCLES cycles the state goes to RUN, so PCF first advances BOOT_CYCLES+1 cycles after reset release.
  - RUN:
    - redirect & !StallF: PCF <= target next edge. FlushD=FlushE=1 in the same cycle. Count increments.
    - redirect & StallF: target is latched into the pending register and the state goes to HOLD. FlushD=FlushE=1 in the same cycle. Count increments.
    - !redirect & !StallF: PCF <= PCF+4.
    - !redirect & StallF: PCF is held.
    - FlushD=FlushE=0 whenever there is no redirect.
  - HOLD:
    - PCF is held while StallF=1.
    - A new redirect while in HOLD overwrites the pending target, asserts the flushes and increments the count.
    - When StallF=0: PCF <= pending target (or the new target, if a redirect is present that same cycle) and the state goes to RUN. Flushes are asserted only if a redirect is present that cycle.
- Redirect latency: one cycle from redirect assertion to the new PCF when unstalled. Sequential PC latency is also one cycle.
- RedirectCount saturates at all-ones and does not wrap.
- PCF+4 wraps from 32'hFFFF_FFFC to 32'h0000_0000.
- X-free: all registers are reset. There is no default-to-zero fallback path for the next PC.

Decomposition:
- Package fetch_pkg:
  - State typedef enum {BOOT, RUN, HOLD}.
  - PC_W=32 and INSTR_BYTES=4 constants.
  - Default RESET_PC.
- Sub-module pc_target_calc (combinational):
  - Inputs: PCE, ImmExtE, ALUResultE, JalrE.
  - Outputs: final target and raw bit-1 flag.
- The state machine, pending register, boot counter and performance counter live in fetch_pc_sequencer.

Test Plan:
- Reset release with BOOT_CYCLES=1 and no stalls -> PCF is 0x0 for 2 cycles, then 0x4, 0x8. FlushD=1 during BOOT.
- RUN with PCF=0x10, PCSrcE=1, PCE=0x8, ImmExtE=0x8 -> same cycle FlushD=FlushE=1; next cycle PCF=0x18; RedirectCount=1.
- JalrE=1 and PCSrcE=1 together, ALUResultE=0x101 -> PCF=0x100 (JALR wins, bit 0 cleared); MisalignE=0.
- Redirect to 0x40 while StallF=1 for 3 cycles -> PCF held 3 cycles, then PCF=0x40. Flushes asserted only in the redirect cycle.
- In HOLD with pending 0x40, a second redirect to 0x80 with StallF still high -> PCF=0x80 after release; RedirectCount=2.
- Branch raw target 0x22 -> MisalignE=1 and PCF=0x20. Reset asserted during HOLD -> PCF=RESET_PC and state=BOOT next cycle.
